// File: rtl/mem_fetch_ctrl_pkg.sv
// Shared types for the frame fetch stage: state encoding, pixel tag layout
// and the read-credit rule.
package fetch_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam int ROW_W = 10;
   localparam int COL_W = 10;
   localparam int TAG_W = ROW_W + COL_W + 1;

   typedef struct packed {
      logic [ROW_W-1:0] row;
      logic [COL_W-1:0] col;
      logic             last;
   } tag_t;

   // Every issued read must already own a FIFO slot once its data returns.
   function automatic logic can_issue(input logic [1:0] count,
                                      input logic       inflight,
                                      input logic       pop);
      logic [2:0] used;
      used = 3'(count) + 3'(inflight) - 3'(pop);
      return used < 3'd2;
   endfunction

endpackage

// File: rtl/mem_fetch_ctrl_if.sv
// BRAM read port plus pixel stream towards the buffer; master is the fetch
// stage, slave is the BRAM/buffer side.
interface mem_fetch_ctrl_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 19
);
   logic                       bram_en_o;
   logic [ADDR_W-1:0]          bram_addr_o;
   logic [DATA_W-1:0]          bram_rdata_i;
   logic                       buf_valid_o;
   logic                       buf_ready_i;
   logic [DATA_W-1:0]          buf_data_o;
   logic [fetch_pkg::ROW_W-1:0] buf_row_o;
   logic [fetch_pkg::COL_W-1:0] buf_col_o;
   logic                       buf_last_o;

   modport master (
      output bram_en_o, bram_addr_o,
      input  bram_rdata_i,
      output buf_valid_o, buf_data_o, buf_row_o, buf_col_o, buf_last_o,
      input  buf_ready_i
   );

   modport slave (
      input  bram_en_o, bram_addr_o,
      output bram_rdata_i,
      input  buf_valid_o, buf_data_o, buf_row_o, buf_col_o, buf_last_o,
      output buf_ready_i
   );
endinterface

// File: rtl/mem_fetch_ctrl_fifo.sv
// Two-entry synchronous FIFO with flush; head entry is visible combinationally
// so the stream output is valid as soon as count is non-zero.
module fetch_fifo2 #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] pop_data,
   output logic [1:0]   count
);
   logic       wr_ptr_reg;
   logic       rd_ptr_reg;
   logic [1:0] count_reg;
   logic [W-1:0] entry_data [2];

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_entry
         logic [W-1:0] data_reg;
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               data_reg <= '0;
            end else if (push && !flush && (wr_ptr_reg == 1'(gi))) begin
               data_reg <= push_data;
            end
         end
         assign entry_data[gi] = data_reg;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_reg <= 1'b0;
         rd_ptr_reg <= 1'b0;
         count_reg  <= 2'd0;
      end else if (flush) begin
         wr_ptr_reg <= 1'b0;
         rd_ptr_reg <= 1'b0;
         count_reg  <= 2'd0;
      end else begin
         if (push) wr_ptr_reg <= ~wr_ptr_reg;
         if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
         count_reg <= count_reg + 2'(push) - 2'(pop);
      end
   end

   assign pop_data = entry_data[rd_ptr_reg];
   assign count    = count_reg;

endmodule

// File: rtl/mem_fetch_ctrl.sv
// Frame fetch stage: streams an IMG_ROW x IMG_COL frame from BRAM in raster
// order to the pixel buffer, one pixel per cycle when the buffer keeps up.
module mem_fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int IMG_ROW   = 540,
   parameter int IMG_COL   = 540,
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 19,
   parameter int BASE_ADDR = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             fetch_run_i,
   output logic             fetch_done_o,
   output logic [1:0]       state_o,
   mem_fetch_ctrl_if.master bus
);
   localparam int FIFO_W = DATA_W + TAG_W;

   state_t            state_reg, state_next;
   logic [ROW_W-1:0]  row_reg, row_next;
   logic [COL_W-1:0]  col_reg, col_next;
   logic [ADDR_W-1:0] addr_reg, addr_next;
   logic [ADDR_W-1:0] last_addr_reg, last_addr_next;
   logic              inflight_reg;
   tag_t              tag_reg;

   logic              issue;
   logic              flush;
   logic              push;
   logic              pop;
   logic              buf_valid;
   logic              at_last;
   logic [1:0]        fifo_count;
   logic [FIFO_W-1:0] fifo_out;
   tag_t              tag_cur;

   assign at_last   = (row_reg == ROW_W'(IMG_ROW - 1)) && (col_reg == COL_W'(IMG_COL - 1));
   assign tag_cur   = '{row: row_reg, col: col_reg, last: at_last};
   assign buf_valid = (fifo_count != 2'd0);
   assign pop       = buf_valid & bus.buf_ready_i;
   // Data returning after an abort belongs to a dead frame and is dropped.
   assign push      = inflight_reg && ((state_reg == S_READ) || (state_reg == S_DRAIN));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg     <= S_IDLE;
         row_reg       <= '0;
         col_reg       <= '0;
         addr_reg      <= '0;
         last_addr_reg <= '0;
         inflight_reg  <= 1'b0;
         tag_reg       <= '0;
      end else begin
         state_reg     <= state_next;
         row_reg       <= row_next;
         col_reg       <= col_next;
         addr_reg      <= addr_next;
         last_addr_reg <= last_addr_next;
         inflight_reg  <= issue;
         if (issue) tag_reg <= tag_cur;
      end
   end

   always_comb begin
      state_next     = state_reg;
      row_next       = row_reg;
      col_next       = col_reg;
      addr_next      = addr_reg;
      last_addr_next = last_addr_reg;
      issue          = 1'b0;
      flush          = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (fetch_run_i) begin
               state_next = S_READ;
               row_next   = '0;
               col_next   = '0;
               addr_next  = ADDR_W'(BASE_ADDR);
            end
         end
         S_READ: begin
            if (!fetch_run_i) begin
               flush      = 1'b1;
               state_next = S_IDLE;
            end else begin
               issue = can_issue(fifo_count, inflight_reg, pop);
               if (issue) begin
                  last_addr_next = addr_reg;
                  addr_next      = addr_reg + ADDR_W'(1);
                  if (at_last) begin
                     state_next = S_DRAIN;
                  end else if (col_reg == COL_W'(IMG_COL - 1)) begin
                     col_next = '0;
                     row_next = row_reg + ROW_W'(1);
                  end else begin
                     col_next = col_reg + COL_W'(1);
                  end
               end
            end
         end
         S_DRAIN: begin
            if (!fetch_run_i) begin
               flush      = 1'b1;
               state_next = S_IDLE;
            end else if (!inflight_reg &&
                         ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop))) begin
               // Leave as soon as the final handshake happens this cycle.
               state_next = S_DONE;
            end
         end
         S_DONE: begin
            if (!fetch_run_i) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   fetch_fifo2 #(
      .W (FIFO_W)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .push      (push),
      .push_data ({bus.bram_rdata_i, tag_reg}),
      .pop       (pop),
      .pop_data  (fifo_out),
      .count     (fifo_count)
   );

   assign bus.bram_en_o   = issue;
   assign bus.bram_addr_o = issue ? addr_reg : last_addr_reg;
   assign bus.buf_valid_o = buf_valid;
   assign {bus.buf_data_o, bus.buf_row_o, bus.buf_col_o, bus.buf_last_o} = fifo_out;
   assign fetch_done_o    = (state_reg == S_DONE);
   assign state_o         = state_reg;

endmodule

// File: tb/tb_mem_fetch_ctrl.sv
// Directed bench for mem_fetch_ctrl on a 4x3 frame; BRAM returns addr[7:0].
module tb_mem_fetch_ctrl;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       fetch_run;
   logic       fetch_done;
   logic [1:0] state;
   int         n_checks = 0;
   int         n_fail   = 0;

   mem_fetch_ctrl_if #(.DATA_W(8), .ADDR_W(19)) bus ();

   mem_fetch_ctrl #(
      .IMG_ROW (4), .IMG_COL (3), .DATA_W (8), .ADDR_W (19), .BASE_ADDR (0)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .fetch_run_i  (fetch_run),
      .fetch_done_o (fetch_done),
      .state_o      (state),
      .bus          (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.bram_en_o) bus.bram_rdata_i <= bus.bram_addr_o[7:0];
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      for (int i = 0; i < 3; i++) begin
         rst_n = 1'b0;
         fetch_run = 1'($urandom);
         bus.buf_ready_i = 1'($urandom);
         @(posedge clk);
         @(negedge clk);
         n_checks++;
         if ({bus.bram_en_o, bus.bram_addr_o, bus.buf_valid_o, bus.buf_data_o, bus.buf_row_o,
              bus.buf_col_o, bus.buf_last_o, fetch_done, state} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs cyc=%0d got en=%b addr=%0d valid=%b data=%0d done=%b state=%0d, required all 0",
                     i, bus.bram_en_o, bus.bram_addr_o, bus.buf_valid_o, bus.buf_data_o, fetch_done, state);
         end
      end
      next_cycle();
      rst_n = 1'b1;
      fetch_run = 1'b0;
      bus.buf_ready_i = 1'b1;
      next_cycle();
   endtask

   // Leaves fetch_run high with the DUT sitting in S_DONE.
   task automatic test_full_throughput;
      int k;
      logic exp_en, exp_valid;
      fetch_run = 1'b1;
      bus.buf_ready_i = 1'b1;
      for (int c = 0; c <= 16; c++) begin
         @(negedge clk);
         exp_en = (c >= 1) && (c <= 12);
         n_checks++;
         if (bus.bram_en_o !== exp_en) begin
            n_fail++;
            $display("FAIL thr_en c=%0d got %b required %b", c, bus.bram_en_o, exp_en);
         end
         if (exp_en) begin
            n_checks++;
            if (bus.bram_addr_o !== 19'(c - 1)) begin
               n_fail++;
               $display("FAIL thr_addr c=%0d got %0d required %0d", c, bus.bram_addr_o, c - 1);
            end
         end
         exp_valid = (c >= 3) && (c <= 14);
         n_checks++;
         if (bus.buf_valid_o !== exp_valid) begin
            n_fail++;
            $display("FAIL thr_valid c=%0d got %b required %b", c, bus.buf_valid_o, exp_valid);
         end
         if (exp_valid) begin
            k = c - 3;
            n_checks++;
            if ({bus.buf_data_o, bus.buf_row_o, bus.buf_col_o, bus.buf_last_o} !==
                {8'(k), 10'(k / 3), 10'(k % 3), (k == 11)}) begin
               n_fail++;
               $display("FAIL thr_pixel c=%0d got data=%0d row=%0d col=%0d last=%b required data=%0d row=%0d col=%0d last=%b",
                        c, bus.buf_data_o, bus.buf_row_o, bus.buf_col_o, bus.buf_last_o,
                        k, k / 3, k % 3, (k == 11));
            end
         end
         n_checks++;
         if (fetch_done !== (c >= 15)) begin
            n_fail++;
            $display("FAIL thr_done c=%0d got %b required %b", c, fetch_done, (c >= 15));
         end
         next_cycle();
      end
   endtask

   task automatic test_backpressure;
      int idx = 0;
      fetch_run = 1'b1;
      for (int c = 0; c <= 24; c++) begin
         bus.buf_ready_i = !((c >= 4) && (c <= 9));
         @(negedge clk);
         if ((c >= 4) && (c <= 9)) begin
            n_checks++;
            if ({bus.bram_en_o, bus.buf_valid_o, bus.buf_data_o} !== {1'b0, 1'b1, 8'd1}) begin
               n_fail++;
               $display("FAIL bp_stall c=%0d got en=%b valid=%b data=%0d required en=0 valid=1 data=1",
                        c, bus.bram_en_o, bus.buf_valid_o, bus.buf_data_o);
            end
         end
         if (bus.buf_valid_o && bus.buf_ready_i) begin
            n_checks++;
            if ((idx >= 12) ||
                ({bus.buf_data_o, bus.buf_row_o, bus.buf_col_o, bus.buf_last_o} !==
                 {8'(idx), 10'(idx / 3), 10'(idx % 3), (idx == 11)})) begin
               n_fail++;
               $display("FAIL bp_pixel c=%0d got data=%0d row=%0d col=%0d last=%b required pixel %0d",
                        c, bus.buf_data_o, bus.buf_row_o, bus.buf_col_o, bus.buf_last_o, idx);
            end
            idx++;
         end
         n_checks++;
         if (fetch_done !== (c >= 21)) begin
            n_fail++;
            $display("FAIL bp_done c=%0d got %b required %b", c, fetch_done, (c >= 21));
         end
         next_cycle();
      end
      n_checks++;
      if (idx != 12) begin
         n_fail++;
         $display("FAIL bp_count got %0d pixels required 12", idx);
      end
      fetch_run = 1'b0;
      next_cycle();
      next_cycle();
   endtask

   task automatic test_abort;
      int hs = 0;
      bus.buf_ready_i = 1'b1;
      for (int c = 0; c <= 13; c++) begin
         fetch_run = (c < 8) || (c >= 10);
         @(negedge clk);
         if ((c < 8) && bus.buf_valid_o && bus.buf_ready_i) hs++;
         if (c == 7) begin
            n_checks++;
            if (hs != 5) begin
               n_fail++;
               $display("FAIL abort_hs got %0d handshakes required 5", hs);
            end
         end
         if (c == 9) begin
            n_checks++;
            if ({state, bus.buf_valid_o, bus.bram_en_o, fetch_done} !== 5'b0) begin
               n_fail++;
               $display("FAIL abort_idle got state=%0d valid=%b en=%b done=%b required 0 0 0 0",
                        state, bus.buf_valid_o, bus.bram_en_o, fetch_done);
            end
         end
         if (c == 11) begin
            n_checks++;
            if ({bus.bram_en_o, bus.bram_addr_o} !== {1'b1, 19'd0}) begin
               n_fail++;
               $display("FAIL abort_restart_addr got en=%b addr=%0d required en=1 addr=0",
                        bus.bram_en_o, bus.bram_addr_o);
            end
         end
         if (c == 13) begin
            n_checks++;
            if ({bus.buf_valid_o, bus.buf_data_o, bus.buf_row_o, bus.buf_col_o} !== {1'b1, 8'd0, 10'd0, 10'd0}) begin
               n_fail++;
               $display("FAIL abort_restart_pixel got valid=%b data=%0d row=%0d col=%0d required 1 0 0 0",
                        bus.buf_valid_o, bus.buf_data_o, bus.buf_row_o, bus.buf_col_o);
            end
         end
         next_cycle();
      end
      fetch_run = 1'b0;
      next_cycle();
      next_cycle();
   endtask

   task automatic test_done_restart;
      test_full_throughput();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if (fetch_done !== 1'b1) begin
            n_fail++;
            $display("FAIL done_hold i=%0d got %b required 1", i, fetch_done);
         end
         next_cycle();
      end
      fetch_run = 1'b0;
      next_cycle();
      @(negedge clk);
      n_checks++;
      if ({fetch_done, state} !== 3'b0) begin
         n_fail++;
         $display("FAIL done_drop got done=%b state=%0d required 0 0", fetch_done, state);
      end
      next_cycle();
      test_full_throughput();
      fetch_run = 1'b0;
      next_cycle();
      next_cycle();
   endtask

   task automatic test_mid_reset;
      int  hs = 0;
      logic seen_done = 1'b0;
      fetch_run = 1'b1;
      for (int c = 0; c <= 14; c++) begin
         bus.buf_ready_i = (c < 13);
         if (c == 14) rst_n = 1'b0;
         @(negedge clk);
         if (c == 14) begin
            n_checks++;
            if ({state, bus.buf_valid_o, bus.buf_data_o} !== {2'd2, 1'b1, 8'd10}) begin
               n_fail++;
               $display("FAIL mr_full got state=%0d valid=%b data=%0d required 2 1 10",
                        state, bus.buf_valid_o, bus.buf_data_o);
            end
         end
         next_cycle();
      end
      @(negedge clk);
      n_checks++;
      if ({bus.bram_en_o, bus.bram_addr_o, bus.buf_valid_o, bus.buf_data_o, bus.buf_row_o,
           bus.buf_col_o, bus.buf_last_o, fetch_done, state} !== '0) begin
         n_fail++;
         $display("FAIL mr_outputs got en=%b addr=%0d valid=%b data=%0d row=%0d col=%0d state=%0d required all 0",
                  bus.bram_en_o, bus.bram_addr_o, bus.buf_valid_o, bus.buf_data_o,
                  bus.buf_row_o, bus.buf_col_o, state);
      end
      next_cycle();
      rst_n = 1'b1;
      fetch_run = 1'b0;
      bus.buf_ready_i = 1'b1;
      next_cycle();
      fetch_run = 1'b1;
      for (int c = 0; c < 30 && !seen_done; c++) begin
         @(negedge clk);
         if (bus.buf_valid_o && bus.buf_ready_i) begin
            n_checks++;
            if (bus.buf_data_o !== 8'(hs)) begin
               n_fail++;
               $display("FAIL mr_pixel got data=%0d required %0d", bus.buf_data_o, hs);
            end
            hs++;
         end
         seen_done = fetch_done;
         next_cycle();
      end
      n_checks++;
      if (!seen_done || hs != 12) begin
         n_fail++;
         $display("FAIL mr_frame got done=%b pixels=%0d required done=1 pixels=12", seen_done, hs);
      end
      fetch_run = 1'b0;
      next_cycle();
      next_cycle();
   endtask

   initial begin
      rst_n = 1'b0;
      fetch_run = 1'b0;
      bus.buf_ready_i = 1'b0;
      test_reset();
      test_full_throughput();
      fetch_run = 1'b0;
      next_cycle();
      next_cycle();
      test_backpressure();
      test_abort();
      test_done_restart();
      test_mid_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
